// File: rtl/debug_dump_serializer.sv
// debug_dump_serializer
//   Captures a NUM_WORDS x WORD_BITS snapshot on request and streams it,
//   word 0 first and least-significant byte first, into a UART transmitter.
//   The transmitter handshake is start/done-tick based.
//   Handshake: o_tx_start is a single-cycle pulse and o_tx_data is valid in
//   that cycle. o_tx_data then stays stable until the transmitter returns
//   i_tx_done_tick. A done tick is only accepted after the pulse cycle, while
//   the byte is outstanding. Ticks at any other time are ignored.
//   Optional feature macro: DUMP_CHECKSUM_EN. When it is defined, the bytes
//   are followed by one XOR checksum byte covering every data byte.
//   o_dbg_state exposes the FSM state for debug visibility.
`timescale 1ns/1ps

module debug_dump_serializer #(
  parameter int NUM_WORDS = 33,
  parameter int WORD_BITS = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [NUM_WORDS*WORD_BITS-1:0] i_snapshot,
  input  logic                           i_tx_done_tick,
  output logic [7:0]                     o_tx_data,
  output logic                           o_tx_start,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [2:0]                     o_dbg_state
);

  localparam int BYTES_WORD = WORD_BITS / 8;
  localparam int WIDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BIDX_W     = (BYTES_WORD > 1) ? $clog2(BYTES_WORD) : 1;
  localparam int SEL_W      = (NUM_WORDS * WORD_BITS > 1) ? $clog2(NUM_WORDS * WORD_BITS) : 1;

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd4
  } state_e;
`endif

  state_e                         state_q;
  logic [NUM_WORDS*WORD_BITS-1:0] shadow_q;
  logic [WIDX_W-1:0]              word_idx_q;
  logic [BIDX_W-1:0]              byte_idx_q;
  logic [7:0]                     tx_data_q;
  logic                           tx_start_q;
  logic                           busy_q;
  logic                           done_q;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]                     csum_q;
`endif

  logic [WIDX_W-1:0] word_idx_d;
  logic [BIDX_W-1:0] byte_idx_d;
  logic [SEL_W-1:0]  sel_off;
  logic [7:0]        next_byte_d;
  logic              last_byte_of_word;
  logic              last_word;

  // Next byte position (byte within word, then word) and the shadow byte it selects.
  always_comb begin
    last_byte_of_word = (byte_idx_q == BIDX_W'(BYTES_WORD - 1));
    last_word         = (word_idx_q == WIDX_W'(NUM_WORDS - 1));
    if (last_byte_of_word) begin
      byte_idx_d = '0;
      word_idx_d = word_idx_q + WIDX_W'(1);
    end else begin
      byte_idx_d = byte_idx_q + BIDX_W'(1);
      word_idx_d = word_idx_q;
    end
    sel_off     = SEL_W'((int'(word_idx_d) * BYTES_WORD + int'(byte_idx_d)) * 8);
    next_byte_d = shadow_q[sel_off +: 8];
  end

  // Dump sequencer with registered outputs. Abort overrides everything except reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else if (i_abort) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_start_q <= 1'b0;
          done_q     <= 1'b0;
          if (i_start) begin
            // Byte 0 comes straight from the input, so the first pulse goes out right after capture.
            shadow_q   <= i_snapshot;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            tx_data_q  <= i_snapshot[7:0];
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= i_snapshot[7:0];
`endif
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          tx_start_q <= 1'b0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done_tick) begin
            if (last_word && last_byte_of_word) begin
`ifdef DUMP_CHECKSUM_EN
              tx_data_q  <= csum_q;
              tx_start_q <= 1'b1;
              state_q    <= ST_CSUM;
`else
              done_q     <= 1'b1;
              state_q    <= ST_DONE;
`endif
            end else begin
              word_idx_q <= word_idx_d;
              byte_idx_q <= byte_idx_d;
              tx_data_q  <= next_byte_d;
              tx_start_q <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
              csum_q     <= csum_q ^ next_byte_d;
`endif
              state_q    <= ST_SEND;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        ST_CSUM: begin
          // The first CSUM cycle carries the pulse; an acknowledge is only valid after it.
          tx_start_q <= 1'b0;
          if (i_tx_done_tick && !tx_start_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_debug_dump_serializer.sv
// Bench for debug_dump_serializer: a 33-word instance (dut0) and a 1-word
// instance (dut1). The bench predicts the outputs from a frame-level reference
// model, which is a queue of the bytes still owed plus the current handshake
// position. The predictions are compared against both DUTs on every falling
// edge. Directed literal checks pin the model.
`timescale 1ns/1ps

module tb_debug_dump_serializer;

  localparam int NW0   = 33;
  localparam int NB0   = NW0 * 4;
`ifdef DUMP_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              start0, abort0, tick0;
  logic [NW0*32-1:0] snap0;
  logic [7:0]        data0;
  logic              txs0, busy0, done0;
  logic [2:0]        dbg0;

  logic              start1, abort1, tick1;
  logic [31:0]       snap1;
  logic [7:0]        data1;
  logic              txs1, busy1, done1;
  logic [2:0]        dbg1;

  debug_dump_serializer #(.NUM_WORDS(NW0), .WORD_BITS(32)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_abort(abort0),
    .i_snapshot(snap0), .i_tx_done_tick(tick0), .o_tx_data(data0),
    .o_tx_start(txs0), .o_busy(busy0), .o_done(done0), .o_dbg_state(dbg0)
  );

  debug_dump_serializer #(.NUM_WORDS(1), .WORD_BITS(32)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(abort1),
    .i_snapshot(snap1), .i_tx_done_tick(tick1), .o_tx_data(data1),
    .o_tx_start(txs1), .o_busy(busy1), .o_done(done1), .o_dbg_state(dbg1)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  bit         m_busy[2];
  bit         m_flight[2];
  bit         m_pulse[2];
  bit         m_done[2];
  logic [7:0] m_data[2];

  logic [7:0] obs0[$];
  logic [7:0] obs1[$];
  int         done_cnt0 = 0;
  int         done_cnt1 = 0;

  // responder controls
  int cnt0 = 0, cnt1 = 0;
  int dly0 = 1, dly1 = 1;
  int ack_idx0 = 0;
  int abort_at0 = -1;
  int rs_at0 = -1;
  bit rs_fire = 1'b0;
  bit stray0 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic q_push(input int d, input logic [7:0] b);
    if (d == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic q_pop(input int d, output logic [7:0] b);
    if (d == 0) b = exp_q0.pop_front();
    else        b = exp_q1.pop_front();
  endtask

  task automatic q_clear(input int d);
    if (d == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  // Whole frame as a byte list: word 0 first, little-endian, optional XOR trailer.
  task automatic build_frame(input int d);
    logic [7:0] b;
    logic [7:0] x;
    int nw;
    x = 8'h00;
    nw = (d == 0) ? NW0 : 1;
    q_clear(d);
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = (d == 0) ? snap0[k*32 + j*8 +: 8] : snap1[j*8 +: 8];
        q_push(d, b);
        x = x ^ b;
      end
    end
`ifdef DUMP_CHECKSUM_EN
    q_push(d, x);
`endif
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_flight[d] = 0; m_pulse[d] = 0; m_done[d] = 0; m_data[d] = 8'h00;
      q_clear(d);
    end
  endtask

  // Advance one clock using the inputs that the next rising edge will sample.
  task automatic model_step(input int d, input logic st, input logic ab, input logic tk);
    logic [7:0] b;
    bit was_pulse;
    if (ab) begin
      m_busy[d] = 0; m_flight[d] = 0; m_pulse[d] = 0; m_done[d] = 0;
      q_clear(d);
    end else if (m_done[d]) begin
      m_done[d] = 0;
      m_busy[d] = 0;
    end else if (!m_busy[d]) begin
      if (st) begin
        build_frame(d);
        q_pop(d, b);
        m_data[d] = b; m_busy[d] = 1; m_pulse[d] = 1; m_flight[d] = 1;
      end
    end else begin
      was_pulse = m_pulse[d];
      m_pulse[d] = 0;
      if (m_flight[d] && !was_pulse && tk) begin
        m_flight[d] = 0;
        if (q_size(d) > 0) begin
          q_pop(d, b);
          m_data[d] = b; m_pulse[d] = 1; m_flight[d] = 1;
        end else begin
          m_done[d] = 1;
        end
      end
    end
  endtask

  task automatic cmp_dut(input int d, input logic st, input logic [7:0] dat,
                         input logic bs, input logic dn);
    chk($sformatf("tx_start%0d", d), {31'b0, st}, {31'b0, m_pulse[d]});
    chk($sformatf("busy%0d", d), {31'b0, bs}, {31'b0, m_busy[d]});
    chk($sformatf("done%0d", d), {31'b0, dn}, {31'b0, m_done[d]});
    if (m_busy[d]) chk($sformatf("tx_data%0d", d), {24'b0, dat}, {24'b0, m_data[d]});
    if (st === 1'b1) begin
      if (d == 0) obs0.push_back(dat);
      else        obs1.push_back(dat);
    end
    if (dn === 1'b1) begin
      if (d == 0) done_cnt0++;
      else        done_cnt1++;
    end
  endtask

  // Compare process: outputs vs model, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_tx_start0", {31'b0, txs0}, 32'd0);
      chk("rst_busy0", {31'b0, busy0}, 32'd0);
      chk("rst_done0", {31'b0, done0}, 32'd0);
      chk("rst_tx_data0", {24'b0, data0}, 32'd0);
      chk("rst_state0", {29'b0, dbg0}, 32'd0);
      chk("rst_tx_start1", {31'b0, txs1}, 32'd0);
      chk("rst_busy1", {31'b0, busy1}, 32'd0);
      chk("rst_done1", {31'b0, done1}, 32'd0);
      chk("rst_state1", {29'b0, dbg1}, 32'd0);
    end else begin
      cmp_dut(0, txs0, data0, busy0, done0);
      cmp_dut(1, txs1, data1, busy1, done1);
      model_step(0, start0, abort0, tick0);
      model_step(1, start1, abort1, tick1);
    end
  end

  // ---------------- UART responders ----------------
  initial begin : responder0
    forever begin
      @(posedge clk);
      #1;
      tick0 = 1'b0;
      abort0 = 1'b0;
      if (rs_fire) begin
        start0 = 1'b0;
        rs_fire = 1'b0;
      end
      if (!rst_n) begin
        cnt0 = 0;
      end else begin
        if (cnt0 > 0) begin
          cnt0--;
          if (cnt0 == 0) begin
            tick0 = 1'b1;
            if (ack_idx0 == abort_at0) begin
              abort0 = 1'b1;
              abort_at0 = -1;
            end
            ack_idx0++;
          end
        end else if (stray0 && !busy0 && $urandom_range(0, 3) == 0) begin
          tick0 = 1'b1;
        end
        if (txs0) begin
          cnt0 = (dly0 > 0) ? dly0 : int'($urandom_range(1, 6));
          if (ack_idx0 == rs_at0) begin
            start0 = 1'b1;
            rs_fire = 1'b1;
            rs_at0 = -1;
          end
        end
      end
    end
  end

  initial begin : responder1
    forever begin
      @(posedge clk);
      #1;
      tick1 = 1'b0;
      if (!rst_n) begin
        cnt1 = 0;
      end else begin
        if (cnt1 > 0) begin
          cnt1--;
          if (cnt1 == 0) tick1 = 1'b1;
        end
        if (txs1) cnt1 = (dly1 > 0) ? dly1 : int'($urandom_range(1, 6));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int d);
    @(posedge clk);
    #1;
    if (d == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    @(posedge clk);
    #1;
    if (d == 0) start0 = 1'b0;
    else        start1 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int base, input int budget, input string name);
    int n;
    n = 0;
    while ((((d == 0) ? done_cnt0 : done_cnt1) == base) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, (((d == 0) ? done_cnt0 : done_cnt1) != base) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_idle0(input int budget, input string name);
    int n;
    n = 0;
    while (m_busy[0] && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, {31'b0, m_busy[0]}, 32'd0);
  endtask

  task automatic rand_snap0();
    for (int k = 0; k < NW0; k++) snap0[k*32 +: 32] = $urandom();
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [7:0]        t2_exp [0:4];
    logic [NW0*32-1:0] cap;
    logic [7:0]        got;
    int                base;
    int                n;
    bit                aborting;

    t2_exp[0] = 8'h44; t2_exp[1] = 8'h33; t2_exp[2] = 8'h22; t2_exp[3] = 8'h11; t2_exp[4] = 8'h44;
    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; tick0 = 1'b0; snap0 = '0;
    start1 = 1'b0; abort1 = 1'b0; tick1 = 1'b0; snap1 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("idle_after_reset_busy0", {31'b0, busy0}, 32'd0);
    chk("idle_after_reset_start0", {31'b0, txs0}, 32'd0);

    // T2: single word, tick 5 cycles after each start
    snap1 = 32'h11223344;
    dly1 = 5;
    obs1.delete();
    base = done_cnt1;
    pulse_start(1);
    wait_done(1, base, 200, "t2_done_seen");
    chk("t2_byte_count", obs1.size(), 4 + EXTRA);
    for (int i = 0; i < 4 + EXTRA; i++) begin
      got = (i < obs1.size()) ? obs1[i] : 8'hxx;
      chk($sformatf("t2_byte%0d", i), {24'b0, got}, {24'b0, t2_exp[i]});
    end

    // T3: full dump, word k = k, tick 1 cycle after each start
    for (int k = 0; k < NW0; k++) snap0[k*32 +: 32] = k;
    dly0 = 1;
    ack_idx0 = 0;
    obs0.delete();
    base = done_cnt0;
    pulse_start(0);
    wait_done(0, base, 3000, "t3_done_seen");
    chk("t3_byte_count", obs0.size(), NB0 + EXTRA);
    for (int i = 0; i < NB0; i++) begin
      got = (i < obs0.size()) ? obs0[i] : 8'hxx;
      chk($sformatf("t3_byte%0d", i), {24'b0, got}, (i % 4 == 0) ? i / 4 : 0);
    end
`ifdef DUMP_CHECKSUM_EN
    got = (NB0 < obs0.size()) ? obs0[NB0] : 8'hxx;
    chk("t3_checksum", {24'b0, got}, 32'h20);
`endif

    // T4: snapshot freeze after the first byte
    rand_snap0();
    cap = snap0;
    dly0 = 0;
    ack_idx0 = 0;
    obs0.delete();
    base = done_cnt0;
    pulse_start(0);
    n = 0;
    while (obs0.size() < 1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    snap0 = '1;
    wait_done(0, base, 3000, "t4_done_seen");
    chk("t4_byte_count", obs0.size(), NB0 + EXTRA);
    for (int i = 0; i < NB0; i++) begin
      got = (i < obs0.size()) ? obs0[i] : 8'hxx;
      chk($sformatf("t4_byte%0d", i), {24'b0, got}, {24'b0, cap[i*8 +: 8]});
    end

    // T5: i_start pulsed while byte 3 is in flight
    rand_snap0();
    ack_idx0 = 0;
    rs_at0 = 3;
    obs0.delete();
    base = done_cnt0;
    pulse_start(0);
    wait_done(0, base, 3000, "t5_done_seen");
    repeat (30) @(posedge clk);
    chk("t5_done_count", done_cnt0 - base, 32'd1);
    chk("t5_byte_count", obs0.size(), NB0 + EXTRA);

    // T6: abort together with the done tick of byte 10, then restart
    rand_snap0();
    ack_idx0 = 0;
    abort_at0 = 10;
    obs0.delete();
    base = done_cnt0;
    pulse_start(0);
    wait_idle0(2000, "t6_abort_idle");
    repeat (5) @(posedge clk);
    chk("t6_no_done", done_cnt0 - base, 32'd0);
    chk("t6_bytes_before_abort", obs0.size(), 32'd11);
    ack_idx0 = 0;
    obs0.delete();
    base = done_cnt0;
    pulse_start(0);
    wait_done(0, base, 3000, "t6_restart_done");
    got = (obs0.size() > 0) ? obs0[0] : 8'hxx;
    chk("t6_restart_first_byte", {24'b0, got}, {24'b0, snap0[7:0]});
    chk("t6_restart_byte_count", obs0.size(), NB0 + EXTRA);

    // T1: asynchronous reset in the middle of a WAIT
    rand_snap0();
    dly0 = 5;
    ack_idx0 = 0;
    pulse_start(0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_tx_start", {31'b0, txs0}, 32'd0);
    chk("t1_async_busy", {31'b0, busy0}, 32'd0);
    chk("t1_async_done", {31'b0, done0}, 32'd0);
    chk("t1_async_tx_data", {24'b0, data0}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("t1_idle_after_release", {31'b0, busy0}, 32'd0);

    // Random frames: random data, ack delays, stray ticks in idle, random aborts
    stray0 = 1'b1;
    for (int f = 0; f < 6; f++) begin
      rand_snap0();
      dly0 = 0;
      repeat ($urandom_range(2, 8)) @(posedge clk);
      ack_idx0 = 0;
      abort_at0 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB0 - 1)) : -1;
      aborting = (abort_at0 >= 0);
      base = done_cnt0;
      pulse_start(0);
      if (aborting) begin
        wait_idle0(2000, "rand_abort_idle");
        chk("rand_abort_no_done", done_cnt0 - base, 32'd0);
      end else begin
        wait_done(0, base, 2000, "rand_done_seen");
      end
    end
    stray0 = 1'b0;
    for (int f = 0; f < 3; f++) begin
      snap1 = $urandom();
      dly1 = 0;
      base = done_cnt1;
      pulse_start(1);
      wait_done(1, base, 200, "rand1_done_seen");
    end
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
